player_motion: RTL and testbench
================================

Name: player_motion

Overview:
Frame-tick-driven fighter motion controller and parametrised successor to the fixed-table mover. Vertical motion uses integer velocity/gravity physics instead of a lookup arc. It adds knockback impulses with friction decay and an opponent body-gap block. Positions are clamped on the same tick they are computed. It sits between the input/attack FSM and the sprite renderer, one instance per player.

Parameters:
POS_WIDTH, 10, position width (unsigned screen coords, Y grows downward)
VEL_WIDTH, 6, signed velocity width (vel_y, knockback)
GROUND_Y, 300, floor Y
START_X, 40, reset X
MIN_X, 40, left wall
MAX_X, 600, right wall
WALK_SPEED, 3, ground step per tick
AIR_SPEED, 2, latched horizontal drift per tick while airborne
JUMP_V0, 12, takeoff upward velocity
GRAVITY, 1, vel_y decrement per tick
KB_FRICTION, 1, knockback magnitude decay per tick
BODY_GAP, 32, minimum ground-walk separation from opponent

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
SCEN  in  1  frame tick (one-cycle strobe)
move_enable  in  1  high = motion allowed; low = full freeze
move_left  in  1  held direction
move_right  in  1  held direction
jump  in  1  jump request
kb_valid  in  1  knockback impulse strobe
kb_vx  in  VEL_WIDTH  signed knockback X velocity
opponent_x  in  POS_WIDTH  opponent X
pos_x  out  POS_WIDTH  X position
pos_y  out  POS_WIDTH  Y position
vel_y  out  VEL_WIDTH  signed vertical velocity (positive = up)
facing_right  out  1  facing toward opponent
move_active  out  1  position changed or airborne this tick
jump_active  out  1  state == AIR
kb_active  out  1  knockback velocity nonzero

Behaviour:
- Reset values: pos_x=START_X, pos_y=GROUND_Y, vel_y=0, facing_right=1, move_active=0, jump_active=0, kb_active=0. Drift and knockback registers are 0. State is GROUND.
- Updates occur only on a clk edge with SCEN&&move_enable (the "tick"). All registers otherwise hold. kb_valid is ignored off-tick. move_enable low freezes physics mid-jump.
- The state machine has two states, GROUND and AIR. kb_active is an orthogonal flag.
- Knockback has top priority. On a tick with kb_valid, kb_vel<=kb_vx, which overrides any residual. kb_vel is applied to X on the following ticks. kb_vel decays toward 0 by KB_FRICTION per tick and saturates at 0, never overshooting. kb_active = (kb_vel != 0).
- GROUND, kb_active=0:
  - jump → AIR, vel_y<=JUMP_V0, drift<=+AIR_SPEED if right-only, -AIR_SPEED if left-only, else 0. X and Y are unchanged on the takeoff tick. move_active=1.
  - Otherwise left-only → X-=WALK_SPEED, and right-only → X+=WALK_SPEED, with move_active=1. Both held or neither held → no move, move_active=0.
- GROUND, kb_active=1: walk and jump inputs are ignored. X+=kb_vel.
- AIR: y_next = pos_y - vel_y, computed signed at POS_WIDTH+2 bits. vel_y-=GRAVITY. X+=drift+kb_vel. Inputs are ignored. If y_next>=GROUND_Y (only possible while vel_y<=0), then pos_y=GROUND_Y, vel_y=0, drift=0, and the state becomes GROUND on the same tick. move_active=1 on every AIR tick, including the landing tick.
- X arithmetic is signed at POS_WIDTH+2 bits. The result is clamped to [MIN_X,MAX_X] on the same tick, so no out-of-range value is ever visible. If the clamp engages, drift<=0 and kb_vel<=0.
- Body gap applies to ground walking only:
  - Walking right with pos_x<opponent_x: X is limited to max(pos_x, opponent_x-BODY_GAP).
  - Walking left with pos_x>opponent_x: X is limited to min(pos_x, opponent_x+BODY_GAP).
  - A blocked step gives move_active=0.
- facing_right updates only in GROUND with kb_active=0: it is set to (new_x<opponent_x). Equal X holds the previous value. Facing is held while in AIR.
- Simultaneous kb_valid and jump: knockback is latched and the jump is dropped.
- Reset asserted mid-jump returns everything to reset values immediately.

Test Plan:
- Reset → pos_x=40, pos_y=300, vel_y=0, facing_right=1, all flags 0. Right held, 10 ticks, opponent_x=500 → pos_x=70, move_active=1 each tick.
- Jump with no direction at x=200 → takeoff tick y=300, vel_y=12. Then y=288, 277, … reaching apex 222 on air tick 12, held at 222 on tick 13. Landing y=300 occurs on air tick 25, with jump_active falling that tick and x=200 throughout.
- Jump with right held at x=590 → drift +2 gives 592, …, 600. The clamp then zeroes drift, and x stays 600 until landing.
- kb_valid with kb_vx=-5 at x=300 on ground → x=295, 291, 288, 286, 285 over the next ticks. kb_active drops once kb_vel reaches 0. Walk and jump inputs are ignored while it is active.
- Opponent_x=300, at x=260, right held → x=263, 266, 268, then held at 268 with move_active=0.
- move_enable low for 5 ticks mid-jump → pos_y and vel_y frozen. The arc resumes exactly where it stopped after re-enable.

Source files
------------

// File: rtl/player_motion_if.sv
// Control/status bundle between the input FSM, one motion controller and the sprite renderer.
interface player_motion_if #(
    parameter int POS_WIDTH = 10,
    parameter int VEL_WIDTH = 6
);
    logic                        SCEN;
    logic                        move_enable;
    logic                        move_left;
    logic                        move_right;
    logic                        jump;
    logic                        kb_valid;
    logic signed [VEL_WIDTH-1:0] kb_vx;
    logic [POS_WIDTH-1:0]        opponent_x;
    logic [POS_WIDTH-1:0]        pos_x;
    logic [POS_WIDTH-1:0]        pos_y;
    logic signed [VEL_WIDTH-1:0] vel_y;
    logic                        facing_right;
    logic                        move_active;
    logic                        jump_active;
    logic                        kb_active;

    modport master (
        output SCEN, move_enable, move_left, move_right, jump, kb_valid, kb_vx, opponent_x,
        input  pos_x, pos_y, vel_y, facing_right, move_active, jump_active, kb_active
    );

    modport slave (
        input  SCEN, move_enable, move_left, move_right, jump, kb_valid, kb_vx, opponent_x,
        output pos_x, pos_y, vel_y, facing_right, move_active, jump_active, kb_active
    );
endinterface

// File: rtl/player_motion.sv
// Per-player motion controller: ground walking with body-gap block, velocity/gravity jump arc,
// decaying knockback, wall clamp applied on the same frame tick as the move.
module player_motion #(
    parameter int POS_WIDTH   = 10,
    parameter int VEL_WIDTH   = 6,
    parameter int GROUND_Y    = 300,
    parameter int START_X     = 40,
    parameter int MIN_X       = 40,
    parameter int MAX_X       = 600,
    parameter int WALK_SPEED  = 3,
    parameter int AIR_SPEED   = 2,
    parameter int JUMP_V0     = 12,
    parameter int GRAVITY     = 1,
    parameter int KB_FRICTION = 1,
    parameter int BODY_GAP    = 32
) (
    input logic           clk,
    input logic           reset,
    player_motion_if.slave bus
);
    localparam int XW = POS_WIDTH + 2;
    localparam logic signed [XW-1:0] MIN_XS = XW'(MIN_X);
    localparam logic signed [XW-1:0] MAX_XS = XW'(MAX_X);
    localparam logic signed [XW-1:0] GND_S  = XW'(GROUND_Y);
    localparam logic signed [XW-1:0] WALK_S = XW'(WALK_SPEED);
    localparam logic signed [XW-1:0] GAP_S  = XW'(BODY_GAP);
    localparam logic signed [VEL_WIDTH-1:0] AIR_V  = VEL_WIDTH'(AIR_SPEED);
    localparam logic signed [VEL_WIDTH-1:0] JUMP_V = VEL_WIDTH'(JUMP_V0);
    localparam logic signed [VEL_WIDTH-1:0] GRAV_V = VEL_WIDTH'(GRAVITY);
    localparam logic signed [VEL_WIDTH-1:0] FRIC_V = VEL_WIDTH'(KB_FRICTION);

    typedef enum logic {GROUND, AIR} state_t;
    state_t state;

    logic [POS_WIDTH-1:0]        pos_x, pos_y;
    logic signed [VEL_WIDTH-1:0] vel_y, drift, kb_vel, kb_next, kb_decay;
    logic                        facing_right, move_active, jump_active, kb_active;

    logic tick, walk_l, walk_r, kb_mode, clamp_hit, land;
    logic signed [XW-1:0] x_cur, opp, x_raw, x_new, lim, y_next;

    function automatic logic signed [XW-1:0] sext(input logic signed [VEL_WIDTH-1:0] v);
        return {{(XW-VEL_WIDTH){v[VEL_WIDTH-1]}}, v};
    endfunction

    always_comb begin
        tick    = bus.SCEN && bus.move_enable;
        walk_l  = bus.move_left && !bus.move_right;
        walk_r  = bus.move_right && !bus.move_left;
        kb_mode = (kb_vel != '0) || bus.kb_valid;
        x_cur   = {2'b00, pos_x};
        opp     = {2'b00, bus.opponent_x};
        y_next  = {2'b00, pos_y} - sext(vel_y);
        lim     = x_cur;
        x_raw   = x_cur;
        if (state == AIR) begin
            x_raw = x_cur + sext(drift) + sext(kb_vel);
        end else if (kb_mode) begin
            x_raw = x_cur + sext(kb_vel);
        end else if (!bus.jump && walk_r) begin
            x_raw = x_cur + WALK_S;
            lim   = (opp - GAP_S > x_cur) ? opp - GAP_S : x_cur;
            if (x_cur < opp && x_raw > lim) x_raw = lim;
        end else if (!bus.jump && walk_l) begin
            x_raw = x_cur - WALK_S;
            lim   = (opp + GAP_S < x_cur) ? opp + GAP_S : x_cur;
            if (x_cur > opp && x_raw < lim) x_raw = lim;
        end
        clamp_hit = (x_raw < MIN_XS) || (x_raw > MAX_XS);
        x_new     = (x_raw < MIN_XS) ? MIN_XS : (x_raw > MAX_XS) ? MAX_XS : x_raw;
        land      = (state == AIR) && (y_next >= GND_S);
        if (kb_vel > FRIC_V)       kb_decay = kb_vel - FRIC_V;
        else if (kb_vel < -FRIC_V) kb_decay = kb_vel + FRIC_V;
        else                       kb_decay = '0;
        // A fresh impulse on the same tick as a wall hit still latches.
        kb_next = bus.kb_valid ? bus.kb_vx : (clamp_hit ? '0 : kb_decay);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= GROUND;
            pos_x        <= POS_WIDTH'(START_X);
            pos_y        <= POS_WIDTH'(GROUND_Y);
            vel_y        <= '0;
            drift        <= '0;
            kb_vel       <= '0;
            facing_right <= 1'b1;
            move_active  <= 1'b0;
            jump_active  <= 1'b0;
            kb_active    <= 1'b0;
        end else if (tick) begin
            kb_vel    <= kb_next;
            kb_active <= (kb_next != '0);
            pos_x     <= x_new[POS_WIDTH-1:0];
            if (state == AIR) begin
                move_active <= 1'b1;
                if (land) begin
                    state       <= GROUND;
                    jump_active <= 1'b0;
                    pos_y       <= POS_WIDTH'(GROUND_Y);
                    vel_y       <= '0;
                    drift       <= '0;
                end else begin
                    pos_y <= y_next[POS_WIDTH-1:0];
                    vel_y <= vel_y - GRAV_V;
                    if (clamp_hit) drift <= '0;
                end
            end else if (!kb_mode && bus.jump) begin
                state       <= AIR;
                jump_active <= 1'b1;
                move_active <= 1'b1;
                vel_y       <= JUMP_V;
                drift       <= walk_r ? AIR_V : (walk_l ? -AIR_V : '0);
                if (x_cur != opp) facing_right <= (x_cur < opp);
            end else begin
                move_active <= (x_new != x_cur);
                if (!kb_mode && x_new != opp) facing_right <= (x_new < opp);
            end
        end
    end

    assign bus.pos_x        = pos_x;
    assign bus.pos_y        = pos_y;
    assign bus.vel_y        = vel_y;
    assign bus.facing_right = facing_right;
    assign bus.move_active  = move_active;
    assign bus.jump_active  = jump_active;
    assign bus.kb_active    = kb_active;
endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed frame sequences with literal expectations, then random frames
// against an integer motion model compared on every clock.
module tb_player_motion;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   run_cmp = 1'b0;

    player_motion_if #(.POS_WIDTH(10), .VEL_WIDTH(6)) bus();

    player_motion dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // ---------------- behavioural model (plain integers) ----------------
    int mx, my, mvy, mdr, mkb;
    bit mair, mface, mma, mja, mka;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_step();
        int opp, kin, dir, dec, tgt, nx, ny;
        bit hit, kbm;
        opp = int'(bus.opponent_x);
        kin = $signed(bus.kb_vx);
        dir = (bus.move_right && !bus.move_left) ? 1 : ((bus.move_left && !bus.move_right) ? -1 : 0);
        dec = (mkb > 1) ? mkb - 1 : ((mkb < -1) ? mkb + 1 : 0);
        kbm = (mkb != 0) || bus.kb_valid;
        tgt = mx;
        if (mair) tgt = mx + mdr + mkb;
        else if (kbm) tgt = mx + mkb;
        else if (!bus.jump && dir != 0) begin
            tgt = mx + 3 * dir;
            if (dir > 0 && mx < opp) tgt = imin(tgt, imax(mx, opp - 32));
            if (dir < 0 && mx > opp) tgt = imax(tgt, imin(mx, opp + 32));
        end
        hit = (tgt < 40) || (tgt > 600);
        nx  = imax(40, imin(600, tgt));
        if (mair) begin
            mma = 1;
            ny  = my - mvy;
            if (ny >= 300) begin
                my = 300; mvy = 0; mdr = 0; mair = 0;
            end else begin
                my = ny; mvy = mvy - 1;
                if (hit) mdr = 0;
            end
        end else if (!kbm && bus.jump) begin
            mair = 1; mvy = 12; mdr = 2 * dir; mma = 1;
            if (mx != opp) mface = (mx < opp);
        end else begin
            mma = (nx != mx);
            if (!kbm && nx != opp) mface = (nx < opp);
        end
        mx  = nx;
        mkb = bus.kb_valid ? kin : (hit ? 0 : dec);
        mka = (mkb != 0);
        mja = mair;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mx = 40; my = 300; mvy = 0; mdr = 0; mkb = 0;
            mair = 0; mface = 1; mma = 0; mja = 0; mka = 0;
        end else if (bus.SCEN && bus.move_enable) begin
            model_step();
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            checks++;
            if (int'(bus.pos_x) != mx || int'(bus.pos_y) != my || int'($signed(bus.vel_y)) != mvy ||
                bus.facing_right != mface || bus.move_active != mma ||
                bus.jump_active != mja || bus.kb_active != mka) begin
                failures++;
                $display("FAIL model_cmp t=%0t got x=%0d y=%0d vy=%0d f=%b ma=%b ja=%b ka=%b want x=%0d y=%0d vy=%0d f=%b ma=%b ja=%b ka=%b",
                         $time, bus.pos_x, bus.pos_y, $signed(bus.vel_y), bus.facing_right, bus.move_active,
                         bus.jump_active, bus.kb_active, mx, my, mvy, mface, mma, mja, mka);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic tick(input bit l, input bit r, input bit j, input bit kv, input int kvx, input int opp);
        bus.SCEN = 1'b1; bus.move_enable = 1'b1;
        bus.move_left = l; bus.move_right = r; bus.jump = j;
        bus.kb_valid = kv; bus.kb_vx = 6'(kvx); bus.opponent_x = 10'(opp);
        @(negedge clk);
    endtask

    task automatic freeze(input int opp);
        bus.SCEN = 1'b1; bus.move_enable = 1'b0;
        bus.move_left = 1'b0; bus.move_right = 1'b1; bus.jump = 1'b1;
        bus.kb_valid = 1'b1; bus.kb_vx = 6'(9); bus.opponent_x = 10'(opp);
        @(negedge clk);
    endtask

    int px, vy;

    initial begin
        bus.SCEN = 0; bus.move_enable = 0; bus.move_left = 0; bus.move_right = 0;
        bus.jump = 0; bus.kb_valid = 0; bus.kb_vx = '0; bus.opponent_x = 10'd500;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_cmp = 1'b1;
        @(negedge clk);
        chk("rst_x", bus.pos_x, 40);
        chk("rst_y", bus.pos_y, 300);
        chk("rst_vy", $signed(bus.vel_y), 0);
        chk("rst_face", bus.facing_right, 1);
        chk("rst_ma", bus.move_active, 0);
        chk("rst_ja", bus.jump_active, 0);
        chk("rst_ka", bus.kb_active, 0);

        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0, 0, 0, 500);
            chk("walk_ma", bus.move_active, 1);
        end
        chk("walk_x70", bus.pos_x, 70);

        for (int i = 0; i < 44; i++) tick(0, 1, 0, 0, 0, 232);
        chk("gap_x200", bus.pos_x, 200);

        tick(0, 0, 1, 0, 0, 500);
        chk("takeoff_y", bus.pos_y, 300);
        chk("takeoff_vy", $signed(bus.vel_y), 12);
        chk("takeoff_ja", bus.jump_active, 1);
        chk("takeoff_ma", bus.move_active, 1);
        for (int k = 1; k <= 25; k++) begin
            tick(0, 0, 0, 0, 0, 500);
            chk("arc_x", bus.pos_x, 200);
            chk("arc_ma", bus.move_active, 1);
            if (k == 1)  chk("arc_y1", bus.pos_y, 288);
            if (k == 2)  chk("arc_y2", bus.pos_y, 277);
            if (k == 12) chk("arc_apex", bus.pos_y, 222);
            if (k == 13) chk("arc_hold", bus.pos_y, 222);
            if (k == 24) chk("arc_ja24", bus.jump_active, 1);
            if (k == 25) begin
                chk("land_y", bus.pos_y, 300);
                chk("land_vy", $signed(bus.vel_y), 0);
                chk("land_ja", bus.jump_active, 0);
            end
        end

        for (int i = 0; i < 131; i++) tick(0, 1, 0, 0, 0, 622);
        chk("gap_x590", bus.pos_x, 590);
        tick(0, 1, 1, 0, 0, 622);
        for (int k = 1; k <= 25; k++) begin
            tick(0, 1, 0, 0, 0, 622);
            px = (590 + 2 * k > 600) ? 600 : 590 + 2 * k;
            chk("drift_x", bus.pos_x, px);
        end
        chk("drift_land_ja", bus.jump_active, 0);

        for (int i = 0; i < 101; i++) tick(1, 0, 0, 0, 0, 268);
        chk("left_x300", bus.pos_x, 300);
        chk("left_face", bus.facing_right, 0);

        tick(0, 0, 0, 1, -5, 268);
        chk("kb_latch_x", bus.pos_x, 300);
        chk("kb_latch_ka", bus.kb_active, 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 1, 0, 0, 268);
            px = (i == 0) ? 295 : (i == 1) ? 291 : (i == 2) ? 288 : (i == 3) ? 286 : 285;
            chk("kb_x", bus.pos_x, px);
            chk("kb_ka", bus.kb_active, (i < 4) ? 1 : 0);
            chk("kb_ja", bus.jump_active, 0);
        end

        for (int i = 0; i < 9; i++) tick(1, 0, 0, 0, 0, 228);
        chk("gap_x260", bus.pos_x, 260);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 0, 0, 300);
            px = (i == 0) ? 263 : (i == 1) ? 266 : 268;
            chk("block_x", bus.pos_x, px);
            chk("block_ma", bus.move_active, (i < 3) ? 1 : 0);
        end

        tick(0, 0, 1, 0, 0, 300);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 300);
        chk("pre_freeze_y", bus.pos_y, 250);
        for (int i = 0; i < 5; i++) begin
            freeze(300);
            chk("freeze_y", bus.pos_y, 250);
            chk("freeze_vy", $signed(bus.vel_y), 7);
        end
        tick(0, 0, 0, 0, 0, 300);
        chk("resume_y", bus.pos_y, 243);
        chk("resume_vy", $signed(bus.vel_y), 6);

        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 300);
        #2 reset = 1'b1;
        #1;
        chk("midjump_rst_y", bus.pos_y, 300);
        chk("midjump_rst_x", bus.pos_x, 40);
        chk("midjump_rst_ja", bus.jump_active, 0);
        vy = $signed(bus.vel_y);
        chk("midjump_rst_vy", vy, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            bus.SCEN        = ($urandom_range(0, 9) < 7);
            bus.move_enable = ($urandom_range(0, 9) < 9);
            bus.move_left   = $urandom_range(0, 1);
            bus.move_right  = $urandom_range(0, 1);
            bus.jump        = ($urandom_range(0, 9) == 0);
            bus.kb_valid    = ($urandom_range(0, 19) == 0);
            bus.kb_vx       = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) bus.opponent_x = 10'($urandom_range(0, 1023));
            reset = ($urandom_range(0, 999) < 2);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
